// File: rtl/base_rr_lat_arb_if.sv
// rtl/base_rr_lat_arb_if.sv - requester/holding-register handshake bundle for base_rr_lat_arb
//
// Purpose: groups the per-requester valid/ready/data/end inputs and the
//          registered output stage into one interface.
// Signals: i_v/i_r/i_d/i_e  requester side, requester k at i_d[k*width +: width]
//          o_v/o_r/o_d/o_e  registered output stage, o_sel = source requester index
// Modports: slave  - the arbiter (consumes requests, drives the output stage)
//           master - the environment (drives requests and downstream ready)
interface base_rr_lat_arb_if #(
    parameter int ways  = 4,
    parameter int width = 32
);
    localparam int selw = $clog2(ways);

    logic [0:ways-1]       i_v;
    logic [0:ways-1]       i_r;
    logic [0:ways*width-1] i_d;
    logic [0:ways-1]       i_e;
    logic                  o_v;
    logic                  o_r;
    logic [0:width-1]      o_d;
    logic                  o_e;
    logic [0:selw-1]       o_sel;

    modport slave (
        input  i_v, i_d, i_e, o_r,
        output i_r, o_v, o_d, o_e, o_sel
    );

    modport master (
        output i_v, i_d, i_e, o_r,
        input  i_r, o_v, o_d, o_e, o_sel
    );
endinterface

// File: rtl/base_rr_lat_arb.sv
// rtl/base_rr_lat_arb.sv - packet-locking round-robin arbiter into one holding register
//
// Purpose: shares a single registered output stage among `ways` requesters.
//          Round-robin between packets; once a requester wins it keeps the
//          stage until its end-flagged beat is accepted.
// Ports:   clk   - clock, rising edge
//          reset - asynchronous, active-high
//          bus   - base_rr_lat_arb_if.slave (i_v/i_r/i_d/i_e in, o_v/o_r/o_d/o_e/o_sel out)
module base_rr_lat_arb #(
    parameter int ways  = 4,
    parameter int width = 32,
    parameter int selw  = $clog2(ways)
) (
    input  logic               clk,
    input  logic               reset,
    base_rr_lat_arb_if.slave   bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [0:selw-1] ptr_q, ptr_d;
    logic [0:selw-1] lock_id_q, lock_id_d;
    logic            lock;

    logic            o_v_q;
    logic [0:width-1] o_d_q;
    logic            o_e_q;
    logic [0:selw-1] o_sel_q;

    logic            gnt_v;
    logic [0:selw-1] gnt_id;
    logic            gnt_e;
    logic [0:width-1] gnt_d;
    logic            ld;
    logic [0:ways-1] i_r_c;

    logic [0:width-1] d_arr [ways];

    // Explicit wrap so non-power-of-two ways never produce an index >= ways.
    function automatic logic [0:selw-1] inc_mod(input logic [0:selw-1] x);
        if (x == selw'(ways - 1)) begin
            return '0;
        end
        return x + selw'(1);
    endfunction

    for (genvar k = 0; k < ways; k++) begin : g_unpack
        assign d_arr[k] = bus.i_d[k*width +: width];
    end

    assign lock = (state_q == LOCKED);

    // Grant search. Candidates are scanned from farthest to nearest so the
    // nearest valid requester at or after ptr overwrites and wins.
    always_comb begin
        int j;
        gnt_v  = 1'b0;
        gnt_id = '0;
        j      = 0;
        if (state_q == LOCKED) begin
            gnt_v  = bus.i_v[lock_id_q];
            gnt_id = lock_id_q;
        end else begin
            for (int n = ways - 1; n >= 0; n--) begin
                j = int'(ptr_q) + n;
                if (j >= ways) begin
                    j = j - ways;
                end
                if (bus.i_v[selw'(j)]) begin
                    gnt_v  = 1'b1;
                    gnt_id = selw'(j);
                end
            end
        end
    end

    assign gnt_e = bus.i_e[gnt_id];
    assign gnt_d = d_arr[gnt_id];
    assign ld    = (~o_v_q | bus.o_r) & gnt_v;

    // Ready is the load enable steered to the granted requester; held low in reset.
    always_comb begin
        i_r_c = '0;
        if (ld && !reset) begin
            i_r_c[gnt_id] = 1'b1;
        end
    end

    // Arbitration state only moves on a load.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_id_d = lock_id_q;
        if (ld) begin
            if (gnt_e) begin
                state_d = IDLE;
                ptr_d   = inc_mod(gnt_id);
            end else begin
                state_d   = LOCKED;
                lock_id_d = gnt_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Holding register: load wins over drain so a drain+load keeps o_v high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_v_q   <= 1'b0;
            o_d_q   <= '0;
            o_e_q   <= 1'b0;
            o_sel_q <= '0;
        end else if (ld) begin
            o_v_q   <= 1'b1;
            o_d_q   <= gnt_d;
            o_e_q   <= gnt_e;
            o_sel_q <= gnt_id;
        end else if (o_v_q && bus.o_r) begin
            o_v_q <= 1'b0;
        end
    end

    assign bus.i_r   = i_r_c;
    assign bus.o_v   = o_v_q;
    assign bus.o_d   = o_d_q;
    assign bus.o_e   = o_e_q;
    assign bus.o_sel = o_sel_q;

    // Input-protocol checker: a requester left waiting (valid, not ready)
    // must keep valid, data and end flag unchanged into the next cycle.
    logic [0:ways-1]       chk_pend;
    logic [0:ways*width-1] chk_d;
    logic [0:ways-1]       chk_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_pend <= '0;
            chk_d    <= '0;
            chk_e    <= '0;
        end else begin
            for (int k = 0; k < ways; k++) begin
                if (chk_pend[k]) begin
                    assert (bus.i_v[k]);
                    assert (bus.i_d[k*width +: width] == chk_d[k*width +: width]);
                    assert (bus.i_e[k] == chk_e[k]);
                end
            end
            chk_pend <= bus.i_v & ~i_r_c;
            chk_d    <= bus.i_d;
            chk_e    <= bus.i_e;
        end
    end

endmodule

// File: tb/tb_base_rr_lat_arb.sv
// tb/tb_base_rr_lat_arb.sv - table-driven scoreboard bench for base_rr_lat_arb
module tb_base_rr_lat_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset3;

    base_rr_lat_arb_if #(.ways(4), .width(32)) bus ();
    base_rr_lat_arb_if #(.ways(3), .width(32)) bus3 ();

    base_rr_lat_arb #(.ways(4), .width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    base_rr_lat_arb #(.ways(3), .width(32)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3)
    );

    typedef struct {
        logic       rst;
        logic [0:3] v;
        logic [0:3] e;
        logic       ordy;
        logic [0:3] exp_r;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic [1:0]  sel;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [0:3] v, input logic [0:3] e,
                       input logic ordy, input logic [0:3] r, input logic ov);
        vec_t t;
        t.rst = rst; t.v = v; t.e = e; t.ordy = ordy; t.exp_r = r; t.exp_ov = ov;
        tbl.push_back(t);
    endtask

    task automatic apply(input vec_t t, input int idx);
        beat_t b;
        reset      = t.rst;
        bus.i_v    = t.v;
        bus.i_e    = t.e;
        bus.o_r    = t.ordy;
        @(negedge clk);
        chk($sformatf("row%0d_i_r", idx), 64'(bus.i_r), 64'(t.exp_r));
        chk($sformatf("row%0d_o_v", idx), 64'(bus.o_v), 64'(t.exp_ov));
        if (t.rst) begin
            chk($sformatf("row%0d_rst_o_sel", idx), 64'(bus.o_sel), 64'(0));
            chk($sformatf("row%0d_rst_o_d", idx), 64'(bus.o_d), 64'(0));
            chk($sformatf("row%0d_rst_o_e", idx), 64'(bus.o_e), 64'(0));
            sb.delete();
        end else begin
            if (bus.o_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL row%0d_sb_empty actual=o_v=1 required=no_beat_pending", idx);
                end else begin
                    chk($sformatf("row%0d_o_d", idx), 64'(bus.o_d), 64'(sb[0].d));
                    chk($sformatf("row%0d_o_e", idx), 64'(bus.o_e), 64'(sb[0].e));
                    chk($sformatf("row%0d_o_sel", idx), 64'(bus.o_sel), 64'(sb[0].sel));
                    if (bus.o_r) begin
                        void'(sb.pop_front());
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (t.exp_r[k]) begin
                    b.d   = 32'h100 + 32'(k);
                    b.e   = t.e[k];
                    b.sel = 2'(k);
                    sb.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic rst, input logic [0:2] v, input logic [0:2] e,
                         input logic [0:2] exp_r, input logic exp_ov, input logic [1:0] exp_sel,
                         input logic exp_lock, input int idx);
        reset3   = rst;
        bus3.i_v = v;
        bus3.i_e = e;
        bus3.o_r = 1'b1;
        @(negedge clk);
        chk($sformatf("w3_c%0d_i_r", idx), 64'(bus3.i_r), 64'(exp_r));
        chk($sformatf("w3_c%0d_o_v", idx), 64'(bus3.o_v), 64'(exp_ov));
        chk($sformatf("w3_c%0d_lock", idx), 64'(dut3.lock), 64'(exp_lock));
        if (exp_ov) begin
            chk($sformatf("w3_c%0d_o_sel", idx), 64'(bus3.o_sel), 64'(exp_sel));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        reset3   = 1'b1;
        bus.i_v  = '0;
        bus.i_e  = '0;
        bus.o_r  = 1'b0;
        bus3.i_v = '0;
        bus3.i_e = '0;
        bus3.o_r = 1'b0;
        for (int k = 0; k < 4; k++) bus.i_d[k*32 +: 32] = 32'h100 + 32'(k);
        for (int k = 0; k < 3; k++) bus3.i_d[k*32 +: 32] = 32'h200 + 32'(k);

        // reset with all requesters valid
        for (int i = 0; i < 3; i++) add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0);
        // rotation, single-beat packets
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0);
        // move ptr to 2, then requester 2 sends a 3-beat packet with 0 and 3 waiting
        add(0, 4'b0100, 4'b1111, 1, 4'b0100, 0);
        add(0, 4'b1011, 4'b1101, 1, 4'b0010, 1);
        add(0, 4'b1011, 4'b1101, 1, 4'b0010, 1);
        add(0, 4'b1011, 4'b1111, 1, 4'b0010, 1);
        add(0, 4'b1001, 4'b1111, 1, 4'b0001, 1);
        add(0, 4'b1001, 4'b1111, 1, 4'b1000, 1);
        // backpressure for 5 cycles, then drain+load in the same cycle
        for (int i = 0; i < 5; i++) add(0, 4'b1001, 4'b1111, 0, 4'b0000, 1);
        add(0, 4'b1001, 4'b1111, 1, 4'b0001, 1);
        add(0, 4'b1001, 4'b1111, 1, 4'b1000, 1);
        add(0, 4'b1001, 4'b1111, 1, 4'b0001, 1);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 0);
        // lock bubble: requester 1 locked, absent 4 cycles while 0 waits
        add(0, 4'b0100, 4'b1011, 1, 4'b0100, 0);
        add(0, 4'b1000, 4'b1011, 1, 4'b0000, 1);
        for (int i = 0; i < 3; i++) add(0, 4'b1000, 4'b1011, 1, 4'b0000, 0);
        add(0, 4'b1100, 4'b1111, 1, 4'b0100, 0);
        add(0, 4'b1000, 4'b1111, 1, 4'b1000, 1);
        add(0, 4'b0000, 4'b1111, 1, 4'b0000, 1);
        add(0, 4'b0000, 4'b1111, 1, 4'b0000, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end
        chk("sb_drained", 64'(sb.size()), 64'(0));

        // three requesters: rotation, lock on 1, reset mid-packet
        step3(1, 3'b111, 3'b111, 3'b000, 0, 2'd0, 0, 0);
        step3(1, 3'b111, 3'b111, 3'b000, 0, 2'd0, 0, 1);
        step3(0, 3'b111, 3'b111, 3'b100, 0, 2'd0, 0, 2);
        step3(0, 3'b111, 3'b111, 3'b010, 1, 2'd0, 0, 3);
        step3(0, 3'b111, 3'b111, 3'b001, 1, 2'd1, 0, 4);
        step3(0, 3'b111, 3'b111, 3'b100, 1, 2'd2, 0, 5);
        step3(0, 3'b111, 3'b111, 3'b010, 1, 2'd0, 0, 6);
        step3(0, 3'b111, 3'b101, 3'b001, 1, 2'd1, 0, 7);
        step3(0, 3'b111, 3'b101, 3'b100, 1, 2'd2, 0, 8);
        step3(0, 3'b111, 3'b101, 3'b010, 1, 2'd0, 0, 9);
        step3(0, 3'b111, 3'b101, 3'b010, 1, 2'd1, 1, 10);
        step3(1, 3'b111, 3'b101, 3'b000, 0, 2'd0, 0, 11);
        step3(0, 3'b111, 3'b111, 3'b100, 0, 2'd0, 0, 12);
        step3(0, 3'b111, 3'b111, 3'b010, 1, 2'd0, 0, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
